i2c_loader: RTL and testbench

Sequencer between the I2C slave command interface and the CPU's single memory port. It arbitrates that port between the CPU and a host-driven loader. It also turns halt/reset/execute command pulses into a held CPU reset and a memory-port gate. While the CPU is halted, bytes written by the host over I2C form a big-endian address pointer followed by auto-incrementing memory writes, so firmware can be loaded without CPU involvement.

---
 rtl/i2c_loader.sv | 167 ++++++++++++++++
 tb/tb_i2c_loader.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/i2c_loader.sv
// Arbitrates the single memory port between the CPU and an I2C-driven firmware loader,
// and turns halt/reset/execute command pulses into a held CPU reset and a memory gate.
module i2c_loader #(
  parameter int AW          = 16,
  parameter int RST_CYCLES  = 16,
  parameter bit BOOT_HALTED = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_halt,
  input  logic          cmd_reset,
  input  logic          cmd_execute,
  input  logic          wr_stb,
  input  logic [7:0]    wr_data,
  output logic [7:0]    status,
  output logic          cpu_rst,
  input  logic          cpu_mem_valid,
  input  logic          cpu_mem_we,
  input  logic [AW-1:0] cpu_mem_addr,
  input  logic [7:0]    cpu_mem_wdata,
  output logic          cpu_mem_ready,
  output logic [7:0]    cpu_mem_rdata,
  output logic          mem_valid,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_wdata,
  input  logic          mem_ready,
  input  logic [7:0]    mem_rdata
);

  localparam int CW = $clog2(RST_CYCLES + 1);

  typedef enum logic [2:0] {
    RUN,
    DRAIN,
    HALT,
    WRITE,
    RST
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [1:0]    idx_q, idx_d;
  logic          ovr_q, ovr_d;
  logic [7:0]    data_q, data_d;
  logic [7:0]    status_q, status_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= BOOT_HALTED ? HALT : RST;
      cnt_q    <= CW'(RST_CYCLES);
      ptr_q    <= '0;
      idx_q    <= 2'd0;
      ovr_q    <= 1'b0;
      data_q   <= 8'h00;
      status_q <= 8'h20;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ptr_q    <= ptr_d;
      idx_q    <= idx_d;
      ovr_q    <= ovr_d;
      data_q   <= data_d;
      status_q <= status_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    ovr_d   = ovr_q;
    data_d  = data_q;

    case (state_q)
      RUN: begin
        if (cmd_halt) begin
          state_d = DRAIN;
        end else if (cmd_reset || cmd_execute) begin
          state_d = RST;
          cnt_d   = CW'(RST_CYCLES);
        end
      end
      DRAIN: begin
        // Never cut a CPU transfer mid-handshake.
        if (!(cpu_mem_valid && !mem_ready)) begin
          state_d = HALT;
        end
      end
      HALT: begin
        if (cmd_halt) begin
          idx_d = 2'd0;
          ovr_d = 1'b0;
        end else if (cmd_reset || cmd_execute) begin
          state_d = RST;
          cnt_d   = CW'(RST_CYCLES);
          idx_d   = 2'd0;
        end else if (wr_stb) begin
          case (idx_q)
            2'd0:    ptr_d[AW-1:8] = (AW-8)'(wr_data);
            2'd1:    ptr_d[7:0]    = wr_data;
            default: begin
              data_d  = wr_data;
              state_d = WRITE;
            end
          endcase
          if (idx_q != 2'd2) begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      WRITE: begin
        if (wr_stb) begin
          ovr_d = 1'b1;
        end
        if (mem_ready) begin
          ptr_d   = ptr_q + AW'(1);
          state_d = HALT;
        end
      end
      RST: begin
        if (cnt_q <= CW'(1)) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = HALT;
    endcase

    status_d = {(state_q == HALT) || (state_q == WRITE), state_q == WRITE,
                state_q == RST, ovr_q, 4'b0000};
  end

  always_comb begin
    mem_valid     = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = '0;
    mem_wdata     = 8'h00;
    cpu_mem_ready = 1'b0;
    cpu_mem_rdata = mem_rdata;
    cpu_rst       = reset || (state_q == RST);
    status        = reset ? 8'h20 : status_q;

    if (!reset) begin
      case (state_q)
        RUN, DRAIN: begin
          mem_valid     = cpu_mem_valid;
          mem_we        = cpu_mem_we;
          mem_addr      = cpu_mem_addr;
          mem_wdata     = cpu_mem_wdata;
          cpu_mem_ready = mem_ready;
        end
        WRITE: begin
          mem_valid = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = ptr_q;
          mem_wdata = data_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_loader.sv
// Directed self-checking bench for i2c_loader with default parameters (AW=16, RST_CYCLES=16, BOOT_HALTED=1).
module tb_i2c_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cmd_halt = 1'b0, cmd_reset = 1'b0, cmd_execute = 1'b0;
  logic        wr_stb = 1'b0;
  logic [7:0]  wr_data = 8'h00;
  logic [7:0]  status;
  logic        cpu_rst;
  logic        cpu_mem_valid = 1'b0, cpu_mem_we = 1'b0;
  logic [15:0] cpu_mem_addr = 16'h0000;
  logic [7:0]  cpu_mem_wdata = 8'h00;
  logic        cpu_mem_ready;
  logic [7:0]  cpu_mem_rdata;
  logic        mem_valid, mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_ready = 1'b0;
  logic [7:0]  mem_rdata = 8'h00;

  int total = 0;
  int bad = 0;

  i2c_loader dut (
    .clk(clk), .reset(reset),
    .cmd_halt(cmd_halt), .cmd_reset(cmd_reset), .cmd_execute(cmd_execute),
    .wr_stb(wr_stb), .wr_data(wr_data), .status(status), .cpu_rst(cpu_rst),
    .cpu_mem_valid(cpu_mem_valid), .cpu_mem_we(cpu_mem_we), .cpu_mem_addr(cpu_mem_addr),
    .cpu_mem_wdata(cpu_mem_wdata), .cpu_mem_ready(cpu_mem_ready), .cpu_mem_rdata(cpu_mem_rdata),
    .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    wr_stb  = 1'b1;
    wr_data = b;
    tick();
    wr_stb  = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; cpu_mem_valid = 1'b1; mem_ready = 1'b1;
    tick(); tick(); #1;
    total++; if (cpu_rst !== 1'b1) begin bad++; $display("[TB] FAIL rst_cpu_rst got=%b want=1", cpu_rst); end
    total++; if (mem_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_mem_valid got=%b want=0", mem_valid); end
    total++; if (cpu_mem_ready !== 1'b0) begin bad++; $display("[TB] FAIL rst_cpu_ready got=%b want=0", cpu_mem_ready); end
    total++; if (status !== 8'h20) begin bad++; $display("[TB] FAIL rst_status got=%h want=20", status); end
    reset = 1'b0;
    tick(); #1;
    total++; if (status !== 8'h80) begin bad++; $display("[TB] FAIL boot_status got=%h want=80", status); end
    total++; if (cpu_rst !== 1'b0) begin bad++; $display("[TB] FAIL boot_cpu_rst got=%b want=0", cpu_rst); end
    total++; if (mem_valid !== 1'b0) begin bad++; $display("[TB] FAIL boot_gate got=%b want=0", mem_valid); end
    total++; if (cpu_mem_ready !== 1'b0) begin bad++; $display("[TB] FAIL boot_cpu_ready got=%b want=0", cpu_mem_ready); end
    cpu_mem_valid = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic test_first_load();
    send_byte(8'h12); send_byte(8'h34); send_byte(8'hAB); #1;
    total++; if (mem_valid !== 1'b1 || mem_we !== 1'b1) begin bad++; $display("[TB] FAIL load_req got=%b%b want=11", mem_valid, mem_we); end
    total++; if (mem_addr !== 16'h1234) begin bad++; $display("[TB] FAIL load_addr got=%h want=1234", mem_addr); end
    total++; if (mem_wdata !== 8'hAB) begin bad++; $display("[TB] FAIL load_data got=%h want=ab", mem_wdata); end
    mem_ready = 1'b1; tick(); mem_ready = 1'b0; #1;
    total++; if (mem_valid !== 1'b0) begin bad++; $display("[TB] FAIL load_done got=%b want=0", mem_valid); end
    send_byte(8'h55); #1;
    total++; if (mem_addr !== 16'h1235) begin bad++; $display("[TB] FAIL load_incr got=%h want=1235", mem_addr); end
    mem_ready = 1'b1; tick(); mem_ready = 1'b0;
  endtask

  task automatic test_wrap();
    cmd_halt = 1'b1; tick(); cmd_halt = 1'b0;
    send_byte(8'hFF); send_byte(8'hFF); send_byte(8'h01);
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (mem_valid !== 1'b1 || mem_addr !== 16'hFFFF || mem_wdata !== 8'h01) begin
        bad++; $display("[TB] FAIL wrap_hold%0d got=%b/%h/%h want=1/ffff/01", i, mem_valid, mem_addr, mem_wdata);
      end
      if (i == 1) begin
        total++; if (status[6] !== 1'b1) begin bad++; $display("[TB] FAIL wrap_busy got=%b want=1", status[6]); end
      end
      tick();
    end
    mem_ready = 1'b1; #1;
    total++; if (mem_valid !== 1'b1 || mem_addr !== 16'hFFFF) begin bad++; $display("[TB] FAIL wrap_last got=%b/%h want=1/ffff", mem_valid, mem_addr); end
    tick(); mem_ready = 1'b0;
    send_byte(8'h02); #1;
    total++; if (mem_addr !== 16'h0000 || mem_wdata !== 8'h02) begin bad++; $display("[TB] FAIL wrap_zero got=%h/%h want=0000/02", mem_addr, mem_wdata); end
    mem_ready = 1'b1; tick(); mem_ready = 1'b0; #1;
    total++; if (mem_valid !== 1'b0) begin bad++; $display("[TB] FAIL wrap_done got=%b want=0", mem_valid); end
  endtask

  task automatic test_execute();
    cmd_execute = 1'b1; tick(); cmd_execute = 1'b0;
    cpu_mem_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      #1;
      total++; if (cpu_rst !== 1'b1) begin bad++; $display("[TB] FAIL exec_rst%0d got=%b want=1", i, cpu_rst); end
      if (i == 0) begin
        total++; if (mem_valid !== 1'b0) begin bad++; $display("[TB] FAIL exec_gate got=%b want=0", mem_valid); end
      end
      if (i == 2) begin
        total++; if (status !== 8'h20) begin bad++; $display("[TB] FAIL exec_status got=%h want=20", status); end
      end
      tick();
    end
    #1;
    total++; if (cpu_rst !== 1'b0) begin bad++; $display("[TB] FAIL exec_release got=%b want=0", cpu_rst); end
    cpu_mem_addr = 16'h4242; mem_rdata = 8'h5A; mem_ready = 1'b1; #1;
    total++; if (mem_valid !== 1'b1 || mem_addr !== 16'h4242) begin bad++; $display("[TB] FAIL run_pass got=%b/%h want=1/4242", mem_valid, mem_addr); end
    total++; if (cpu_mem_ready !== 1'b1 || cpu_mem_rdata !== 8'h5A) begin bad++; $display("[TB] FAIL run_ready got=%b/%h want=1/5a", cpu_mem_ready, cpu_mem_rdata); end
    mem_ready = 1'b0;
  endtask

  task automatic test_drain();
    cpu_mem_valid = 1'b1; cpu_mem_we = 1'b0; cpu_mem_addr = 16'h0100; mem_ready = 1'b0;
    cmd_halt = 1'b1; #1;
    total++; if (mem_valid !== 1'b1) begin bad++; $display("[TB] FAIL drain_c1 got=%b want=1", mem_valid); end
    tick(); cmd_halt = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      total++; if (mem_valid !== 1'b1 || cpu_mem_ready !== 1'b0) begin
        bad++; $display("[TB] FAIL drain_stall%0d got=%b/%b want=1/0", i, mem_valid, cpu_mem_ready);
      end
      tick();
    end
    mem_ready = 1'b1; #1;
    total++; if (cpu_mem_ready !== 1'b1 || mem_valid !== 1'b1) begin bad++; $display("[TB] FAIL drain_done got=%b/%b want=1/1", cpu_mem_ready, mem_valid); end
    tick(); #1;
    total++; if (mem_valid !== 1'b0 || cpu_mem_ready !== 1'b0) begin bad++; $display("[TB] FAIL drain_gated got=%b/%b want=0/0", mem_valid, cpu_mem_ready); end
    tick(); #1;
    total++; if (status !== 8'h80) begin bad++; $display("[TB] FAIL drain_status got=%h want=80", status); end
    cpu_mem_valid = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic test_overrun();
    send_byte(8'h00); send_byte(8'h10); send_byte(8'h77); #1;
    total++; if (mem_valid !== 1'b1 || mem_addr !== 16'h0010) begin bad++; $display("[TB] FAIL ovr_write got=%b/%h want=1/0010", mem_valid, mem_addr); end
    send_byte(8'h88);
    tick(); #1;
    total++; if (status[4] !== 1'b1) begin bad++; $display("[TB] FAIL ovr_flag got=%b want=1", status[4]); end
    total++; if (mem_wdata !== 8'h77 || mem_addr !== 16'h0010) begin bad++; $display("[TB] FAIL ovr_hold got=%h/%h want=77/0010", mem_wdata, mem_addr); end
    mem_ready = 1'b1; tick(); mem_ready = 1'b0;
    cmd_halt = 1'b1; tick(); cmd_halt = 1'b0;
    tick(); #1;
    total++; if (status[4] !== 1'b0) begin bad++; $display("[TB] FAIL ovr_clear got=%b want=0", status[4]); end
    send_byte(8'h00); send_byte(8'h20); send_byte(8'h99); #1;
    total++; if (mem_addr !== 16'h0020 || mem_wdata !== 8'h99) begin bad++; $display("[TB] FAIL ovr_idx got=%h/%h want=0020/99", mem_addr, mem_wdata); end
    mem_ready = 1'b1; tick(); mem_ready = 1'b0;
  endtask

  task automatic test_halt_reset_same();
    int n = 0;
    cmd_reset = 1'b1; tick(); cmd_reset = 1'b0;
    while (cpu_rst === 1'b1 && n < 40) begin
      tick();
      n++;
    end
    total++; if (cpu_rst !== 1'b0) begin bad++; $display("[TB] FAIL prio_timeout got=%b want=0", cpu_rst); end
    cmd_halt = 1'b1; cmd_reset = 1'b1; tick(); cmd_halt = 1'b0; cmd_reset = 1'b0; #1;
    total++; if (cpu_rst !== 1'b0) begin bad++; $display("[TB] FAIL prio_drain got=%b want=0", cpu_rst); end
    tick(); #1;
    total++; if (cpu_rst !== 1'b0) begin bad++; $display("[TB] FAIL prio_halt got=%b want=0", cpu_rst); end
    tick(); #1;
    total++; if (status !== 8'h80) begin bad++; $display("[TB] FAIL prio_status got=%h want=80", status); end
  endtask

  task automatic test_reset_mid_write();
    send_byte(8'h00); send_byte(8'h50); send_byte(8'h11); #1;
    total++; if (mem_valid !== 1'b1 || mem_addr !== 16'h0050) begin bad++; $display("[TB] FAIL mid_write got=%b/%h want=1/0050", mem_valid, mem_addr); end
    reset = 1'b1; #1;
    total++; if (mem_valid !== 1'b0) begin bad++; $display("[TB] FAIL mid_gate got=%b want=0", mem_valid); end
    tick(); reset = 1'b0;
    tick(); #1;
    total++; if (mem_valid !== 1'b0 || cpu_rst !== 1'b0) begin bad++; $display("[TB] FAIL mid_after got=%b/%b want=0/0", mem_valid, cpu_rst); end
    total++; if (status !== 8'h80) begin bad++; $display("[TB] FAIL mid_status got=%h want=80", status); end
    send_byte(8'h00); send_byte(8'h60); send_byte(8'h22); #1;
    total++; if (mem_addr !== 16'h0060 || mem_wdata !== 8'h22) begin bad++; $display("[TB] FAIL mid_idx got=%h/%h want=0060/22", mem_addr, mem_wdata); end
    mem_ready = 1'b1; tick(); mem_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_first_load();
    test_wrap();
    test_execute();
    test_drain();
    test_overrun();
    test_halt_reset_same();
    test_reset_mid_write();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
